// File: rtl/adder_err_eval_ctrl.sv
// Stimulus sequencer and error accumulator for evaluating an approximate adder against an exact adder.
// Optional random (LFSR) sweep is built in only when ADDER_ERR_EVAL_LFSR_EN is defined; otherwise every run is exhaustive.
module adder_err_eval_ctrl #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 5,
  parameter int DUT_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [IN_W-1:0]         seed,
  input  logic [IN_W-1:0]         num_vec,
  output logic [IN_W-1:0]         pi_o,
  input  logic [OUT_W-1:0]        po_i,
  output logic                    busy,
  output logic                    done,
  output logic [IN_W:0]           err_cnt,
  output logic [OUT_W-1:0]        max_err,
  output logic [IN_W+OUT_W-1:0]   sum_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          HALF_W     = IN_W / 2;
  localparam logic [IN_W:0] FULL_CNT = {1'b1, {IN_W{1'b0}}};
  localparam logic [1:0]  DRAIN_LAST = (DUT_LAT > 0) ? 2'(DUT_LAT - 1) : 2'd0;

  logic [1:0]       state;
  logic [IN_W:0]    issued;
  logic [IN_W:0]    total;
  logic [1:0]       drain_cnt;

  logic             issue;
  logic [IN_W-1:0]  issue_vec;
  logic [IN_W-1:0]  first_vec;
  logic [IN_W-1:0]  next_vec;
  logic [IN_W:0]    run_len;

  logic [OUT_W-1:0] exact_pipe [DUT_LAT+1];
  logic [DUT_LAT:0] valid_pipe;
  logic [OUT_W-1:0] ref_sum;
  logic [OUT_W-1:0] err;

  function automatic logic [OUT_W-1:0] exact_sum(input logic [IN_W-1:0] v);
    return OUT_W'(v[HALF_W-1:0]) + OUT_W'(v[IN_W-1:HALF_W]);
  endfunction

`ifdef ADDER_ERR_EVAL_LFSR_EN
  logic mode_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
    return {s[IN_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, seed, num_vec};
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    first_vec = '0;
    run_len   = FULL_CNT;
    next_vec  = pi_o + IN_W'(1);
`ifdef ADDER_ERR_EVAL_LFSR_EN
    if (mode) begin
      first_vec = (seed == '0) ? IN_W'(1) : seed;
      run_len   = (num_vec == '0) ? FULL_CNT : {1'b0, num_vec};
    end
    if (mode_q) next_vec = lfsr_next(pi_o);
`endif
  end

  assign issue     = ((state == S_IDLE) && start) || ((state == S_DRIVE) && (issued != total));
  assign issue_vec = (state == S_IDLE) ? first_vec : next_vec;

  assign busy = (state == S_DRIVE) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pi_o      <= '0;
      issued    <= '0;
      total     <= '0;
      drain_cnt <= '0;
`ifdef ADDER_ERR_EVAL_LFSR_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      if (issue) begin
        pi_o   <= issue_vec;
        issued <= (state == S_IDLE) ? (IN_W+1)'(1) : issued + (IN_W+1)'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_DRIVE;
            total <= run_len;
`ifdef ADDER_ERR_EVAL_LFSR_EN
            mode_q <= mode;
`endif
          end
        end
        S_DRIVE: begin
          if (issued == total) begin
            state     <= (DUT_LAT > 0) ? S_DRAIN : S_DONE;
            drain_cnt <= DRAIN_LAST;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) state <= S_DONE;
          else                   drain_cnt <= drain_cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the exact-sum delay line is only DUT_LAT+1 entries deep, so it is reset along with its valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      for (int i = 0; i <= DUT_LAT; i++) exact_pipe[i] <= '0;
    end else begin
      valid_pipe[0] <= issue;
      exact_pipe[0] <= exact_sum(issue_vec);
      for (int i = 1; i <= DUT_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        exact_pipe[i] <= exact_pipe[i-1];
      end
    end
  end

  assign ref_sum = exact_pipe[DUT_LAT];
  assign err     = (po_i >= ref_sum) ? (po_i - ref_sum) : (ref_sum - po_i);

  // A start always lands in IDLE with an empty pipeline, so clearing takes priority safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      max_err <= '0;
      sum_err <= '0;
    end else if ((state == S_IDLE) && start) begin
      err_cnt <= '0;
      max_err <= '0;
      sum_err <= '0;
    end else if (valid_pipe[DUT_LAT]) begin
      if (err != '0)     err_cnt <= err_cnt + (IN_W+1)'(1);
      if (err > max_err) max_err <= err;
      sum_err <= sum_err + (IN_W+OUT_W)'(err);
    end
  end

endmodule

// File: tb/tb_adder_err_eval_ctrl.sv
// Self-checking bench: two instances (latency 0 and 2) scored against a vector-list/prefix-sum model of each run.
module tb_adder_err_eval_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] num_vec = 8'h00;

  logic [7:0]  pi0, pi2;
  logic [4:0]  po0, po2;
  logic        busy0, busy2, done0, done2;
  logic [8:0]  ec0, ec2;
  logic [4:0]  me0, me2;
  logic [12:0] se0, se2;

  logic [7:0] p1 = 8'h00, p2 = 8'h00;
  logic [4:0] lut [256];
  int kind = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int phase = 0;
  int dcnt0 = 0, dcnt2 = 0, dt0 = -1, dt2 = -1;

  int n_vec = 256;
  int vecs [256];
  int pre_cnt [257];
  int pre_max [257];
  int pre_sum [257];

  always #5 clk = ~clk;

  adder_err_eval_ctrl #(.IN_W(8), .OUT_W(5), .DUT_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed), .num_vec(num_vec),
    .pi_o(pi0), .po_i(po0), .busy(busy0), .done(done0),
    .err_cnt(ec0), .max_err(me0), .sum_err(se0));

  adder_err_eval_ctrl #(.IN_W(8), .OUT_W(5), .DUT_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed), .num_vec(num_vec),
    .pi_o(pi2), .po_i(po2), .busy(busy2), .done(done2),
    .err_cnt(ec2), .max_err(me2), .sum_err(se2));

  function automatic int exact_of(input int v);
    return (v & 15) + ((v >> 4) & 15);
  endfunction

  // Adder models under evaluation: 0 exact, 1 tied to zero, 2 bit 0 forced low, 3 exact xor random pattern.
  function automatic logic [4:0] model_po(input int k, input logic [7:0] v, input logic [4:0] r);
    int e;
    e = exact_of(int'(v));
    case (k)
      0:       return 5'(e);
      1:       return 5'd0;
      2:       return 5'(e & 30);
      default: return 5'(e) ^ r;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  assign po0 = model_po(kind, pi0, lut[pi0]);
  assign po2 = model_po(kind, p2, lut[p2]);

  // The latency-2 adder: its output follows pi_o by two clock cycles.
  always @(posedge clk) begin
    p1 <= pi2;
    p2 <= p1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic build_model(input int k, input logic m, input logic [7:0] sd, input logic [7:0] nv);
    logic [7:0] s;
    int e, pv;
    n_vec = 256;
    for (int i = 0; i < 256; i++) vecs[i] = i;
`ifdef ADDER_ERR_EVAL_LFSR_EN
    if (m) begin
      n_vec = (nv == 8'd0) ? 256 : int'(nv);
      s = (sd == 8'd0) ? 8'h01 : sd;
      for (int i = 0; i < n_vec; i++) begin
        vecs[i] = int'(s);
        s = lfsr_step(s);
      end
    end
`else
    s = sd ^ nv ^ {7'd0, m};
`endif
    pre_cnt[0] = 0; pre_max[0] = 0; pre_sum[0] = 0;
    for (int i = 0; i < n_vec; i++) begin
      pv = int'(model_po(k, 8'(vecs[i]), lut[vecs[i]]));
      e  = pv - exact_of(vecs[i]);
      if (e < 0) e = -e;
      pre_cnt[i+1] = pre_cnt[i] + ((e != 0) ? 1 : 0);
      pre_max[i+1] = (e > pre_max[i]) ? e : pre_max[i];
      pre_sum[i+1] = pre_sum[i] + e;
    end
  endtask

  task automatic cmp(input string p, input int lat, input logic [7:0] pi, input logic b, input logic d,
                     input logic [8:0] ec, input logic [4:0] me, input logic [12:0] se);
    int t, ns, idx;
    if (phase == 0) begin
      check({p, " pi_o"}, pi, 0);
      check({p, " busy"}, b, 0);
      check({p, " done"}, d, 0);
      check({p, " err_cnt"}, ec, 0);
      check({p, " max_err"}, me, 0);
      check({p, " sum_err"}, se, 0);
    end else begin
      t   = cyc - start_cyc;
      ns  = t - lat;
      if (ns < 0) ns = 0;
      if (ns > n_vec) ns = n_vec;
      idx = (t < n_vec) ? t : n_vec - 1;
      check({p, " pi_o"}, pi, vecs[idx]);
      check({p, " busy"}, b, (t < n_vec + lat) ? 1 : 0);
      check({p, " done"}, d, (t == n_vec + lat) ? 1 : 0);
      check({p, " err_cnt"}, ec, pre_cnt[ns]);
      check({p, " max_err"}, me, pre_max[ns]);
      check({p, " sum_err"}, se, pre_sum[ns]);
    end
  endtask

  // Single compare process, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cmp("lat0", 0, pi0, busy0, done0, ec0, me0, se0);
    cmp("lat2", 2, pi2, busy2, done2, ec2, me2, se2);
    if (phase == 1 && done0 === 1'b1) begin dcnt0++; dt0 = cyc - start_cyc; end
    if (phase == 1 && done2 === 1'b1) begin dcnt2++; dt2 = cyc - start_cyc; end
  end

  task automatic start_run(input int k, input logic m, input logic [7:0] sd, input logic [7:0] nv);
    @(negedge clk);
    kind = k; mode = m; seed = sd; num_vec = nv;
    build_model(k, m, sd, nv);
    dcnt0 = 0; dcnt2 = 0; dt0 = -1; dt2 = -1;
    start = 1'b1;
    start_cyc = cyc + 1;
    phase = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int k, input logic m, input logic [7:0] sd, input logic [7:0] nv, input bit disturb,
                     input int first_lit, input int cnt_lit, input int max_lit, input int sum_lit,
                     input int len0_lit, input int len2_lit);
    int t;
    start_run(k, m, sd, nv);
    if (first_lit >= 0) check("first_vec", pi0, first_lit);
    t = cyc - start_cyc;
    while (t < n_vec + 5) begin
      @(negedge clk);
      t = cyc - start_cyc;
      start = (disturb && (t == 5 || t == 50 || t == n_vec)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_pulses_lat0", dcnt0, 1);
    check("done_pulses_lat2", dcnt2, 1);
    if (cnt_lit >= 0) begin
      check("final_err_cnt_lat0", ec0, cnt_lit);
      check("final_max_err_lat0", me0, max_lit);
      check("final_sum_err_lat0", se0, sum_lit);
      check("final_err_cnt_lat2", ec2, cnt_lit);
      check("final_max_err_lat2", me2, max_lit);
      check("final_sum_err_lat2", se2, sum_lit);
    end
    // Run length counts the start cycle through the done cycle inclusive.
    if (len0_lit >= 0) check("run_len_lat0", dt0 + 1, len0_lit);
    if (len2_lit >= 0) check("run_len_lat2", dt2 + 1, len2_lit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 5'($urandom_range(0, 31));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exhaustive sweeps with hand-computed totals.
    run(0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 257, 259);
    run(1, 1'b0, 8'h00, 8'h00, 1'b0, 0, 255, 30, 3840, 257, 259);
    run(2, 1'b0, 8'h00, 8'h00, 1'b0, 0, 128, 1, 128, 257, 259);

    // Starts while busy, and in the DONE cycle of the latency-0 instance, must be ignored.
    run(1, 1'b0, 8'h00, 8'h00, 1'b1, 0, 255, 30, 3840, 257, 259);

    // Reset in the middle of a run, then a clean full pass.
    start_run(1, 1'b0, 8'h00, 8'h00);
    while (cyc - start_cyc < 100) @(negedge clk);
    rst_n = 1'b0;
    phase = 0;
    #1;
    check("rst_pi_o", pi0, 0);
    check("rst_busy", busy0, 0);
    check("rst_err_cnt", ec0, 0);
    check("rst_sum_err", se0, 0);
    check("rst_pi_o_lat2", pi2, 0);
    check("rst_sum_err_lat2", se2, 0);
    check("rst_no_done", dcnt0 + dcnt2, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(1, 1'b0, 8'h00, 8'h00, 1'b0, 0, 255, 30, 3840, 257, 259);

`ifdef ADDER_ERR_EVAL_LFSR_EN
    run(0, 1'b1, 8'h00, 8'h01, 1'b0, 1, 0, 0, 0, 2, 4);
    run(0, 1'b1, 8'hA5, 8'h03, 1'b0, 165, 0, 0, 0, 4, 6);
    check("lfsr_model_v0", vecs[0], 8'hA5);
    check("lfsr_model_v1", vecs[1], 8'h4A);
    check("lfsr_model_v2", vecs[2], 8'h95);
    for (int r = 0; r < 3; r++)
      run(3, 1'b1, 8'($urandom), 8'($urandom), 1'b0, -1, -1, 0, 0, -1, -1);
`else
    // Without the LFSR build, random requests still produce a full exhaustive pass.
    run(0, 1'b1, 8'h00, 8'h01, 1'b0, 0, 0, 0, 0, 257, 259);
    run(3, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 0, -1, 0, 0, 257, 259);
`endif
    run(3, 1'b0, 8'h00, 8'h00, 1'b0, 0, -1, 0, 0, 257, 259);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_err_eval_ctrl.md
# adder_err_eval_ctrl

Sequencer that evaluates an external approximate adder with 8 inputs and 5 outputs (two 4-bit operands, 5-bit sum) against an exact adder. It drives the stimulus bus, samples the adder output, and accumulates error metrics: error count, maximum absolute error and sum of absolute errors. It sits beside the device under evaluation in the error-evaluation harness and replaces file-driven vector lists with on-chip exhaustive or pseudo-random sweeps.

## Interface
- IN_W, 8, total stimulus width. Operand A = pi_o[IN_W/2-1:0], operand B = pi_o[IN_W-1:IN_W/2].
- OUT_W, 5, adder output width. Must be IN_W/2+1.
- DUT_LAT, 0, cycles from pi_o change to the matching po_i being valid. Range 0..3.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- mode  in  1  0 = exhaustive, 1 = random (LFSR). Sampled with start.
- seed  in  IN_W  LFSR seed; 0 is replaced by 1. Sampled with start.
- num_vec  in  IN_W  number of random vectors; 0 means 2^IN_W. Sampled with start.
- pi_o  out  IN_W  stimulus to the adder; registered.
- po_i  in  OUT_W  adder output.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results final.
- err_cnt  out  IN_W+1  number of vectors with po_i != exact.
- max_err  out  OUT_W  maximum |po_i - exact|.
- sum_err  out  IN_W+OUT_W  sum of |po_i - exact|.

## Operation
- The FSM has four states: IDLE, DRIVE, DRAIN, DONE.
  - IDLE → DRIVE on start. Capture mode, seed and num_vec. Clear err_cnt, max_err and sum_err. Load the first vector into pi_o.
  - DRIVE: present one new vector per cycle. After the last vector is issued, go to DRAIN if DUT_LAT>0, else go to DONE.
  - DRAIN: wait DUT_LAT cycles for the final samples, then go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Exhaustive mode: vectors 0,1,…,2^IN_W-1 in ascending order; 256 vectors at default width.
- Random mode: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. The first vector is the seed. Exactly num_vec vectors are issued, or 256 if num_vec is 0.
- Scoring pipeline:
  - Each issued vector's exact sum (A+B, computed at OUT_W bits) is delayed DUT_LAT cycles alongside a valid bit.
  - Each valid sample is scored as |po_i - exact|, unsigned, OUT_W bits.
  - Scoring a sample:
    - err_cnt is incremented if the error is nonzero.
    - max_err is updated if the error is larger than the current value.
    - The error is added to sum_err.
- Accumulator widths are sized so they cannot overflow at maximum error on every vector (256 × 31 < 2^13).
- Results hold after done until the next accepted start.
- start while busy is ignored and has no effect on the run.
- pi_o holds its last vector while in DRAIN, DONE and IDLE.
- Reset value of every output is 0: pi_o, busy, done, err_cnt, max_err and sum_err.

## Timing
- start sampled high at edge 0 → first vector on pi_o and busy=1 after edge 0.
- The vector issued at edge k is scored at edge k+1+DUT_LAT.
- Run length from start to the done pulse is N + DUT_LAT + 1 cycles; exhaustive N = 256.
- done and busy: done is high for exactly one cycle, and busy falls in that same cycle.
- Reset mid-run:
  - rst_n low asynchronously clears all state and all outputs.
  - There is no partial result and no done pulse.
  - After release the block is in IDLE and waits for start.
- start arriving in the DONE cycle is ignored; it must be reasserted in IDLE.

## Configuration
- ADDER_ERR_EVAL_LFSR_EN defined:
  - The LFSR and random mode are built in.
  - mode, seed and num_vec behave as described above.
- Not defined:
  - No LFSR is built.
  - mode, seed and num_vec are ignored, and every run is exhaustive.
  - Port list is unchanged.

## Test plan
- Exact adder model on po_i, exhaustive, DUT_LAT=0 → done at cycle 257; err_cnt=0, max_err=0, sum_err=0.
- po_i tied to 0, exhaustive → err_cnt=255, max_err=30, sum_err=3840.
- po_i = exact with bit 0 forced to 0, DUT_LAT=2 (bench delays the model output by 2 cycles) → err_cnt=128, max_err=1, sum_err=128; done at cycle 259.
- Random mode with seed=0x00 and num_vec=1 → single vector pi_o=0x01; busy for 1 vector; with an exact model, err_cnt=0. With seed=0xA5 and num_vec=3, pi_o sequence matches the LFSR reference model.
- rst_n pulsed low at cycle 100 of an exhaustive run → all outputs 0 immediately and no done. A new start runs a full 256-vector pass with correct totals.
- start reasserted at cycles 5 and 50 of a run → ignored; totals equal those of an undisturbed run and exactly one done pulse.
